// File: rtl/cache_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cache_pkg: geometry and engine state shared by the data-cache blocks. Rev 1.0
// ----------------------------------------------------------------------------
package cache_pkg;

  localparam int BYTE_W   = 8;
  localparam int NBYTES   = 4;
  localparam int OFFSET_W = $clog2(NBYTES);
  localparam int ADDR_W   = 6;
  localparam int LINE_W   = NBYTES * BYTE_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MERGE   = 2'd1,
    WB_REQ  = 2'd2,
    WB_WAIT = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/byte_lane_insert.sv
`default_nettype none
// ----------------------------------------------------------------------------
// byte_lane_insert: replaces one byte lane of a cache block (lane 0 = LSBs). Rev 1.0
// ----------------------------------------------------------------------------
module byte_lane_insert
  import cache_pkg::*;
(
  input  logic [LINE_W-1:0]   line_in,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [BYTE_W-1:0]   wr_byte,
  output logic [LINE_W-1:0]   line_out
);

  always_comb begin
    line_out = line_in;
    for (int i = 0; i < NBYTES; i++) begin
      if (offset == OFFSET_W'(i)) begin
        line_out[i*BYTE_W +: BYTE_W] = wr_byte;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/block_write_merger.sv
`default_nettype none
// ----------------------------------------------------------------------------
// block_write_merger: byte-store merge and dirty-line write-back engine. Rev 1.0
// ----------------------------------------------------------------------------
module block_write_merger
  import cache_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET,
  input  logic                WR_REQ,
  input  logic [OFFSET_W-1:0] WR_OFFSET,
  input  logic [BYTE_W-1:0]   WR_BYTE,
  input  logic [LINE_W-1:0]   LINE_IN,
  input  logic                EVICT_REQ,
  input  logic [ADDR_W-1:0]   EVICT_ADDR,
  output logic [LINE_W-1:0]   LINE_OUT,
  output logic                LINE_WE,
  output logic                BUSY,
  output logic                MEM_WRITE,
  output logic [ADDR_W-1:0]   MEM_ADDRESS,
  output logic [LINE_W-1:0]   MEM_WRITEDATA,
  input  logic                MEM_BUSYWAIT
);

  state_t              state_q, state_d;
  logic [LINE_W-1:0]   line_out_q, line_out_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]   mem_data_q, mem_data_d;
  logic [LINE_W-1:0]   merged_line;

  byte_lane_insert u_insert (
    .line_in  (LINE_IN),
    .offset   (WR_OFFSET),
    .wr_byte  (WR_BYTE),
    .line_out (merged_line)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      line_out_q <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      line_out_q <= line_out_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  // Requests are only looked at in IDLE; eviction wins and drops the store.
  always_comb begin
    state_d    = state_q;
    line_out_d = line_out_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    case (state_q)
      IDLE: begin
        if (EVICT_REQ) begin
          mem_addr_d = EVICT_ADDR;
          mem_data_d = LINE_IN;
          state_d    = WB_REQ;
        end else if (WR_REQ) begin
          line_out_d = merged_line;
          state_d    = MERGE;
        end
      end
      MERGE:   state_d = IDLE;
      WB_REQ:  state_d = WB_WAIT;
      WB_WAIT: begin
        if (!MEM_BUSYWAIT) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign LINE_OUT      = line_out_q;
  assign LINE_WE       = (state_q == MERGE);
  assign BUSY          = (state_q != IDLE);
  assign MEM_WRITE     = (state_q == WB_REQ) || (state_q == WB_WAIT);
  assign MEM_ADDRESS   = mem_addr_q;
  assign MEM_WRITEDATA = mem_data_q;

endmodule
`default_nettype wire

// File: tb/tb_block_write_merger.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_block_write_merger: scoreboard bench for the write merger. Rev 1.0
// ----------------------------------------------------------------------------
module tb_block_write_merger;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        WR_REQ = 1'b0;
  logic [1:0]  WR_OFFSET = '0;
  logic [7:0]  WR_BYTE = '0;
  logic [31:0] LINE_IN = '0;
  logic        EVICT_REQ = 1'b0;
  logic [5:0]  EVICT_ADDR = '0;
  logic [31:0] LINE_OUT;
  logic        LINE_WE;
  logic        BUSY;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic        MEM_BUSYWAIT = 1'b0;

  block_write_merger dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .WR_REQ        (WR_REQ),
    .WR_OFFSET     (WR_OFFSET),
    .WR_BYTE       (WR_BYTE),
    .LINE_IN       (LINE_IN),
    .EVICT_REQ     (EVICT_REQ),
    .EVICT_ADDR    (EVICT_ADDR),
    .LINE_OUT      (LINE_OUT),
    .LINE_WE       (LINE_WE),
    .BUSY          (BUSY),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } wb_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] merge_q [$];
  wb_t         wb_q [$];
  logic [31:0] exp_line_out = '0;
  logic        prev_mw = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference merge: split into bytes, overwrite one, reassemble.
  function automatic logic [31:0] merge_ref(input logic [31:0] line, input int off, input logic [7:0] b);
    logic [7:0] lanes [4];
    for (int k = 0; k < 4; k++) lanes[k] = 8'((line >> (8 * k)) & 32'hFF);
    lanes[off % 4] = b;
    return {lanes[3], lanes[2], lanes[1], lanes[0]};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_merge(input logic [31:0] line, input logic [1:0] off, input logic [7:0] b);
    exp_line_out = merge_ref(line, int'(off), b);
    merge_q.push_back(exp_line_out);
    LINE_IN = line; WR_OFFSET = off; WR_BYTE = b; WR_REQ = 1'b1;
    step();
    WR_REQ = 1'b0;
    LINE_IN = $urandom;
    check("merge_busy", 32'(BUSY), 32'd1);
    step();
    check("merge_done_busy", 32'(BUSY), 32'd0);
    check("merge_hold_line_out", LINE_OUT, exp_line_out);
  endtask

  task automatic do_evict(input logic [5:0] addr, input logic [31:0] data, input int waits,
                          input bit with_wr, input bit junk);
    wb_t e;
    e.addr = addr; e.data = data;
    wb_q.push_back(e);
    EVICT_ADDR = addr; LINE_IN = data; EVICT_REQ = 1'b1; MEM_BUSYWAIT = 1'b1;
    if (with_wr) begin
      WR_REQ = 1'b1; WR_OFFSET = 2'($urandom); WR_BYTE = 8'($urandom);
    end
    step();
    EVICT_REQ = junk; WR_REQ = junk;
    EVICT_ADDR = 6'($urandom); LINE_IN = $urandom;
    MEM_BUSYWAIT = 1'($urandom);
    check("wb_req_mem_write", 32'(MEM_WRITE), 32'd1);
    check("wb_req_busy", 32'(BUSY), 32'd1);
    step();
    MEM_BUSYWAIT = 1'b1;
    for (int i = 0; i < waits; i++) begin
      LINE_IN = $urandom;
      step();
      check("wb_wait_mem_write", 32'(MEM_WRITE), 32'd1);
    end
    MEM_BUSYWAIT = 1'b0;
    step();
    EVICT_REQ = 1'b0; WR_REQ = 1'b0;
    check("wb_end_mem_write", 32'(MEM_WRITE), 32'd0);
    check("wb_end_busy", 32'(BUSY), 32'd0);
    check("wb_line_out_kept", LINE_OUT, exp_line_out);
  endtask

  always @(negedge CLK) begin
    if (RESET !== 1'b1) begin
      if (LINE_WE === 1'b1) begin
        check("line_we_vs_mem_write", 32'(MEM_WRITE), 32'd0);
        if (merge_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_line_we actual=1 expected=0");
        end else begin
          check("merge_line_out", LINE_OUT, merge_q.pop_front());
        end
      end
      if (MEM_WRITE === 1'b1) begin
        if (wb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_mem_write actual=1 expected=0");
        end else begin
          check("wb_address", 32'(MEM_ADDRESS), 32'(wb_q[0].addr));
          check("wb_writedata", MEM_WRITEDATA, wb_q[0].data);
        end
      end
    end
    if (prev_mw === 1'b1 && MEM_WRITE === 1'b0 && wb_q.size() > 0) void'(wb_q.pop_front());
    prev_mw = MEM_WRITE;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1;
    repeat (2) step();
    check("rst_line_out", LINE_OUT, 32'h0);
    check("rst_line_we", 32'(LINE_WE), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_mem_write", 32'(MEM_WRITE), 32'd0);
    check("rst_mem_address", 32'(MEM_ADDRESS), 32'd0);
    check("rst_mem_writedata", MEM_WRITEDATA, 32'h0);
    RESET = 1'b0;
    step();

    do_merge(32'h44332211, 2'd2, 8'hAA);
    check("directed_merge", LINE_OUT, 32'h44AA2211);
    do_evict(6'h2D, 32'hDEADBEEF, 4, 1'b0, 1'b0);
    do_evict(6'h11, 32'hCAFEF00D, 2, 1'b1, 1'b0);
    check("simul_line_out", LINE_OUT, 32'h44AA2211);
    do_evict(6'h3F, 32'h01234567, 3, 1'b0, 1'b1);

    // Abort a write-back with reset while memory is still busy.
    begin
      wb_t e;
      e.addr = 6'h0A; e.data = 32'hA5A5A5A5;
      wb_q.push_back(e);
      EVICT_ADDR = e.addr; LINE_IN = e.data; EVICT_REQ = 1'b1; MEM_BUSYWAIT = 1'b1;
      step();
      EVICT_REQ = 1'b0;
      repeat (2) step();
      check("abort_pre_mem_write", 32'(MEM_WRITE), 32'd1);
      RESET = 1'b1;
      step();
      check("abort_mem_write", 32'(MEM_WRITE), 32'd0);
      check("abort_busy", 32'(BUSY), 32'd0);
      check("abort_line_out", LINE_OUT, 32'h0);
      RESET = 1'b0; MEM_BUSYWAIT = 1'b0;
      exp_line_out = '0;
      step();
    end
    do_merge(32'h12345678, 2'd3, 8'h9C);
    check("lane3_merge", LINE_OUT, 32'h9C345678);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 2) != 0) begin
        do_merge($urandom, 2'($urandom), 8'($urandom));
      end else begin
        do_evict(6'($urandom), $urandom, int'($urandom_range(0, 4)),
                 1'($urandom), 1'($urandom));
      end
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (3) step();
    check("merge_queue_drained", 32'(merge_q.size()), 32'd0);
    check("wb_queue_drained", 32'(wb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
